// File: rtl/dcache_blocking_pkg.sv
// Shared types and default sizing for the data-RAM burst engine.
//   op_e    : command opcode carried on cmd_op
//   state_e : burst sequencer state
//   *_DEF   : default geometry (ways, sets, words per line, word width)
package dcache_blocking_pkg;

  typedef enum logic [1:0] {
    OP_WORD_RD = 2'd0,
    OP_WORD_WR = 2'd1,
    OP_LINE_RD = 2'd2,
    OP_LINE_WR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LINE_RD = 2'd1,
    ST_LINE_WR = 2'd2
  } state_e;

  localparam int WAYS_N_DEF       = 4;
  localparam int SETS_N_DEF       = 64;
  localparam int LINE_WORDS_N_DEF = 4;
  localparam int WORD_W_DEF       = 32;

endpackage

// File: rtl/spram.sv
// Single-port byte-lane RAM, one-cycle registered read, no reset on contents.
//   clk       : clock
//   cmd_en    : access enable (read when cmd_wen=0, write when cmd_wen=1)
//   cmd_wen   : write enable for this lane
//   cmd_addr  : word address
//   cmd_wdata : write byte
//   rsp_rdata : read byte, valid the cycle after a read access; held otherwise
module spram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              cmd_en,
  input  logic              cmd_wen,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic [7:0]        rsp_rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cmd_en) begin
      if (cmd_wen) mem[cmd_addr] <= cmd_wdata;
      else         rsp_rdata     <= mem[cmd_addr];
    end
  end

endmodule

// File: rtl/ram_dat_burst.sv
// Cache data-RAM access engine: single-word reads/writes and critical-word-first
// line bursts over WAYS_N x (WORD_W/8) byte-lane RAMs, with a 2-entry response FIFO.
//   clk, rst               : clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy        : command handshake; cmd_op/way/set/word/wdata/be payload
//   wr_vld/wr_rdy, wr_data : LINE_WR data beats
//   rsp_vld/rsp_rdy        : read response handshake; rsp_data, rsp_last payload
//   busy                   : burst in progress or response data pending
module ram_dat_burst
  import dcache_blocking_pkg::*;
#(
  parameter int WAYS_N       = WAYS_N_DEF,
  parameter int SETS_N       = SETS_N_DEF,
  parameter int LINE_WORDS_N = LINE_WORDS_N_DEF,
  parameter int WORD_W       = WORD_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_vld,
  output logic                            cmd_rdy,
  input  logic [1:0]                      cmd_op,
  input  logic [$clog2(WAYS_N)-1:0]       cmd_way,
  input  logic [$clog2(SETS_N)-1:0]       cmd_set,
  input  logic [$clog2(LINE_WORDS_N)-1:0] cmd_word,
  input  logic [WORD_W-1:0]               cmd_wdata,
  input  logic [WORD_W/8-1:0]             cmd_be,
  input  logic                            wr_vld,
  output logic                            wr_rdy,
  input  logic [WORD_W-1:0]               wr_data,
  output logic                            rsp_vld,
  input  logic                            rsp_rdy,
  output logic [WORD_W-1:0]               rsp_data,
  output logic                            rsp_last,
  output logic                            busy
);

  localparam int WAY_W  = $clog2(WAYS_N);
  localparam int SET_W  = $clog2(SETS_N);
  localparam int IDX_W  = $clog2(LINE_WORDS_N);
  localparam int ADDR_W = SET_W + IDX_W;
  localparam int BYTES  = WORD_W / 8;
  localparam int DEPTH  = SETS_N * LINE_WORDS_N;

  op_e               op;
  state_e            state_q, state_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [IDX_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  logic              ram_en;
  logic [WAY_W-1:0]  ram_way;
  logic [ADDR_W-1:0] ram_addr;
  logic [BYTES-1:0]  ram_wen;
  logic [WORD_W-1:0] ram_wdata;
  logic              rd_issue, rd_issue_last;

  logic              rd_pend_q, rd_last_q;
  logic [WAY_W-1:0]  rd_way_q;
  logic [WAYS_N-1:0] way_en;
  logic [WAYS_N-1:0][WORD_W-1:0] way_rdata;
  logic [WORD_W-1:0] rdata_sel;

  logic [WORD_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              fifo_wp, fifo_rp;
  logic [1:0]        fifo_cnt;
  logic              buf_free, push, pop;

  assign op = op_e'(cmd_op);

  // A new read may only launch if it cannot overflow the 2-entry buffer,
  // counting the read whose data is still coming out of the RAM.
  assign buf_free = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !rd_pend_q);

  always_comb begin
    state_d       = state_q;
    way_d         = way_q;
    set_d         = set_q;
    word_d        = word_q;
    cnt_d         = cnt_q;
    ram_en        = 1'b0;
    ram_way       = way_q;
    ram_addr      = {set_q, word_q};
    ram_wen       = '0;
    ram_wdata     = wr_data;
    rd_issue      = 1'b0;
    rd_issue_last = 1'b0;
    cmd_rdy       = 1'b0;
    wr_rdy        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy = buf_free;
        if (cmd_vld && buf_free) begin
          way_d    = cmd_way;
          set_d    = cmd_set;
          ram_way  = cmd_way;
          ram_addr = {cmd_set, cmd_word};
          case (op)
            OP_WORD_RD: begin
              ram_en        = 1'b1;
              rd_issue      = 1'b1;
              rd_issue_last = 1'b1;
            end
            OP_WORD_WR: begin
              ram_en    = 1'b1;
              ram_wen   = cmd_be;
              ram_wdata = cmd_wdata;
            end
            OP_LINE_RD: begin
              // Critical word goes out in the accept cycle.
              ram_en   = 1'b1;
              rd_issue = 1'b1;
              word_d   = cmd_word + IDX_W'(1);
              cnt_d    = IDX_W'(1);
              state_d  = ST_LINE_RD;
            end
            default: begin
              word_d  = cmd_word;
              cnt_d   = '0;
              state_d = ST_LINE_WR;
            end
          endcase
        end
      end
      ST_LINE_RD: begin
        if (buf_free) begin
          ram_en        = 1'b1;
          rd_issue      = 1'b1;
          rd_issue_last = (cnt_q == IDX_W'(LINE_WORDS_N - 1));
          word_d        = word_q + IDX_W'(1);
          cnt_d         = cnt_q + IDX_W'(1);
          if (rd_issue_last) state_d = ST_IDLE;
        end
      end
      ST_LINE_WR: begin
        wr_rdy = 1'b1;
        if (wr_vld) begin
          ram_en  = 1'b1;
          ram_wen = '1;
          word_d  = word_q + IDX_W'(1);
          cnt_d   = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(LINE_WORDS_N - 1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      way_q     <= '0;
      set_q     <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      rd_way_q  <= '0;
    end else begin
      state_q   <= state_d;
      way_q     <= way_d;
      set_q     <= set_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_issue;
      if (rd_issue) begin
        rd_last_q <= rd_issue_last;
        rd_way_q  <= ram_way;
      end
    end
  end

  // Stage p0 -> p1: RAM access, only the addressed way is enabled.
  for (genvar w = 0; w < WAYS_N; w++) begin : g_way
    assign way_en[w] = ram_en && (ram_way == WAY_W'(w));
    for (genvar b = 0; b < BYTES; b++) begin : g_lane
      spram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
        .clk      (clk),
        .cmd_en   (way_en[w]),
        .cmd_wen  (ram_wen[b]),
        .cmd_addr (ram_addr),
        .cmd_wdata(ram_wdata[8*b +: 8]),
        .rsp_rdata(way_rdata[w][8*b +: 8])
      );
    end
  end

  assign rdata_sel = way_rdata[rd_way_q];

  // Stage p1 -> out: RAM data bypasses the FIFO when it is empty and the
  // consumer is ready; otherwise it is parked so the output stays stable.
  assign push = rd_pend_q && !((fifo_cnt == 2'd0) && rsp_rdy);
  assign pop  = (fifo_cnt != 2'd0) && rsp_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_cnt <= 2'd0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
    end else begin
      if (push) fifo_wp <= ~fifo_wp;
      if (pop)  fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wp] <= rdata_sel;
      fifo_last[fifo_wp] <= rd_last_q;
    end
  end

  assign rsp_vld  = (fifo_cnt != 2'd0) || rd_pend_q;
  assign rsp_data = (fifo_cnt != 2'd0) ? fifo_data[fifo_rp] : rdata_sel;
  assign rsp_last = rsp_vld && ((fifo_cnt != 2'd0) ? fifo_last[fifo_rp] : rd_last_q);
  assign busy     = (state_q != ST_IDLE) || rsp_vld;

endmodule
